// File: rtl/matrix_pkg.sv
// matrix_pkg: shared state encoding and sizing constants for the matrix collector.
package matrix_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERROR} state_t;
  localparam int BUF_DEPTH_DEF = 64;
  localparam int DIM_W = 3;
  localparam int CNT_W = 4;
endpackage

// File: rtl/matrix_stream_collector_if.sv
// matrix_stream_collector_if: element write stream plus random-access readout port.
interface matrix_stream_collector_if #(parameter int AW = 6);
  logic [7:0] data_in;
  logic write_en;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0] rd_data;
  logic rd_valid;
  modport master (output data_in, write_en, rd_en, rd_addr, input rd_data, rd_valid);
  modport slave (input data_in, write_en, rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/matrix_buf_ram.sv
// matrix_buf_ram: simple dual-port element store with registered read; contents are not reset.
module matrix_buf_ram #(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [7:0] wdata,
  input logic re,
  input logic [AW-1:0] raddr,
  output logic [7:0] rdata,
  output logic rvalid
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read samples the pre-write contents, so a same-address write is seen one read later
  always_ff @(posedge clk)
    if (rst) begin
      rdata <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= ({1'b0, raddr} < (AW+1)'(DEPTH)) ? mem[raddr] : 8'h00;
    end
endmodule

// File: rtl/matrix_stream_collector.sv
// matrix_stream_collector: collects count matrices of dim_m x dim_n bytes into a buffer,
// range-checking each element and exposing progress counters and a readout port.
module matrix_stream_collector
  import matrix_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int AW = $clog2(BUF_DEPTH)
) (
  input logic clk,
  input logic rst,
  input logic signed [7:0] elem_min_cfg,
  input logic signed [7:0] elem_max_cfg,
  input logic start_collect,
  input logic [DIM_W-1:0] dim_m,
  input logic [DIM_W-1:0] dim_n,
  input logic [CNT_W-1:0] count,
  output logic busy,
  output logic collect_done,
  output logic param_err,
  output logic stray_flag,
  output logic [7:0] range_err_cnt,
  output logic [CNT_W-1:0] mat_idx,
  output logic [5:0] elem_idx,
  output logic [AW:0] stored_cnt,
  matrix_stream_collector_if.slave bus
);
  state_t state, state_nx;
  logic [5:0] elem_total, total_nx;
  logic [CNT_W-1:0] count_r;
  logic go, legal, accept, wrap, last, oor;
  assign total_nx = {3'b0, dim_m} * {3'b0, dim_n};
  assign legal = dim_m != '0 && dim_n != '0 && count != '0 &&
                 ({4'b0, total_nx} * {6'b0, count}) <= 10'(BUF_DEPTH);
  assign go = state == IDLE && start_collect;
  assign accept = state == COLLECT && bus.write_en;
  assign wrap = elem_idx == elem_total - 6'd1;
  assign last = accept && wrap && mat_idx == count_r - CNT_W'(1);
  assign oor = $signed(bus.data_in) < elem_min_cfg || $signed(bus.data_in) > elem_max_cfg;
  assign busy = state == COLLECT;
  assign collect_done = state == DONE;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (go ? (legal ? COLLECT : ERROR) : IDLE)
             : state == COLLECT ? (last ? DONE : COLLECT) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      param_err <= 1'b0;
      stray_flag <= 1'b0;
      range_err_cnt <= '0;
      mat_idx <= '0;
      elem_idx <= '0;
      stored_cnt <= '0;
      elem_total <= '0;
      count_r <= '0;
    end else begin
      state <= state_nx;
      stray_flag <= (stray_flag && !(go && legal)) || (bus.write_en && state != COLLECT);
      if (go) begin
        elem_total <= total_nx;
        count_r <= count;
        param_err <= !legal;
        if (legal) begin
          range_err_cnt <= '0;
          mat_idx <= '0;
          elem_idx <= '0;
          stored_cnt <= '0;
        end
      end
      if (accept) begin
        stored_cnt <= stored_cnt + 1'b1;
        elem_idx <= wrap ? 6'd0 : elem_idx + 6'd1;
        mat_idx <= mat_idx + CNT_W'(wrap);
        range_err_cnt <= range_err_cnt + 8'(oor && range_err_cnt != 8'hff);
      end
    end
  matrix_buf_ram #(.DEPTH(BUF_DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(accept),
    .waddr(stored_cnt[AW-1:0]),
    .wdata(bus.data_in),
    .re(bus.rd_en),
    .raddr(bus.rd_addr),
    .rdata(bus.rd_data),
    .rvalid(bus.rd_valid)
  );
endmodule
